// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions used by the CPU-side bus masters and slave wrappers.
package ahb_pkg;

    localparam int AHB_DATA_BITS  = 32;
    localparam int AHB_TRANS_BITS = 2;
    localparam int AHB_SIZE_BITS  = 3;
    localparam int AHB_RESP_BITS  = 2;

    localparam logic [3:0] M2_ID = 4'b0001;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001
    } hburst_t;

endpackage

// File: rtl/ahb_align_chk.sv
// Combinational natural-alignment check of a CPU access (shared by the I- and D-port masters).
module ahb_align_chk
    import ahb_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic       misaligned
);

    always_comb begin
        misaligned = 1'b0;
        case (size)
            HSIZE_HALF: misaligned = addr_lo[0];
            HSIZE_WORD: misaligned = |addr_lo;
            default:    misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/dm_ahb_master.sv
// CPU data-port AHB-Lite master: one CPU load/store becomes one SINGLE transfer,
// with the CPU stalled until an ack (and optional error) pulse returns.
module dm_ahb_master
    import ahb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req,
    input  logic                      cpu_write,
    input  logic [AHB_SIZE_BITS-1:0]  cpu_size,
    input  logic [31:0]               cpu_addr,
    input  logic [AHB_DATA_BITS-1:0]  cpu_wdata,
    output logic                      cpu_stall,
    output logic [AHB_DATA_BITS-1:0]  cpu_rdata,
    output logic                      cpu_ack,
    output logic                      cpu_err,
    output logic                      HBUSREQ,
    output logic                      HLOCK,
    input  logic                      HGRANT,
    output logic [AHB_TRANS_BITS-1:0] HTRANS,
    output logic [31:0]               HADDR,
    output logic                      HWRITE,
    output logic [AHB_SIZE_BITS-1:0]  HSIZE,
    output logic [2:0]                HBURST,
    output logic [AHB_DATA_BITS-1:0]  HWDATA,
    input  logic [AHB_DATA_BITS-1:0]  HRDATA,
    input  logic                      HREADY,
    input  logic [AHB_RESP_BITS-1:0]  HRESP
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_DATA, S_DONE} state_t;

    typedef struct packed {
        logic                     write;
        logic [AHB_SIZE_BITS-1:0] size;
        logic [31:0]              addr;
        logic [AHB_DATA_BITS-1:0] wdata;
    } req_t;

    state_t                   state, state_d;
    req_t                     req_q;
    logic [AHB_DATA_BITS-1:0] rdata_q;
    logic                     err_q;
    logic [7:0]               wait_cnt;

    logic misaligned;
    logic latch_req, finish, finish_err, capture, cnt_clr, cnt_inc;

    ahb_align_chk u_align (
        .size       (cpu_size),
        .addr_lo    (cpu_addr[1:0]),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d    = state;
        latch_req  = 1'b0;
        finish     = 1'b0;
        finish_err = 1'b0;
        capture    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        HBUSREQ    = 1'b0;
        HTRANS     = HTRANS_IDLE;
        HWDATA     = '0;
        cpu_ack    = 1'b0;
        cpu_err    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu_req) begin
                    latch_req = 1'b1;
                    if (misaligned) begin
                        // Reject locally: never touch the bus for a misaligned access.
                        finish     = 1'b1;
                        finish_err = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                HBUSREQ = 1'b1;
                if (HGRANT && HREADY) state_d = S_ADDR;
            end
            S_ADDR: begin
                HTRANS  = HTRANS_NONSEQ;
                cnt_clr = 1'b1;
                if (HREADY)       state_d = S_DATA;
                else if (!HGRANT) state_d = S_REQ;
            end
            S_DATA: begin
                HWDATA = req_q.write ? req_q.wdata : '0;
                if (HREADY) begin
                    case (hresp_t'(HRESP))
                        HRESP_OKAY: begin
                            finish  = 1'b1;
                            capture = !req_q.write;
                            state_d = S_DONE;
                        end
                        HRESP_ERROR: begin
                            finish     = 1'b1;
                            finish_err = 1'b1;
                            state_d    = S_DONE;
                        end
                        default: begin
                            cnt_clr = 1'b1;
                            state_d = S_REQ;
                        end
                    endcase
                end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_DONE: begin
                cpu_ack = 1'b1;
                cpu_err = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            req_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (latch_req) req_q <= '{cpu_write, cpu_size, cpu_addr, cpu_wdata};
            if (cnt_clr)      wait_cnt <= '0;
            else if (cnt_inc) wait_cnt <= wait_cnt + 8'd1;
            // Result register only changes on entry to DONE, so loads stay visible afterwards.
            if (finish) begin
                err_q   <= finish_err;
                rdata_q <= capture ? HRDATA : '0;
            end
        end
    end

    assign cpu_stall = ((state != S_IDLE) && (state != S_DONE)) || ((state == S_IDLE) && cpu_req);
    assign cpu_rdata = rdata_q;
    assign HLOCK     = 1'b0;
    assign HBURST    = HBURST_SINGLE;
    assign HADDR     = req_q.addr;
    assign HWRITE    = req_q.write;
    assign HSIZE     = req_q.size;

endmodule

// File: doc/dm_ahb_master.md
Name: dm_ahb_master

Overview:
- AHB-Lite master wrapper for the CPU data-memory port (master M2, HMASTER=4'b0001).
- Converts single CPU load/store requests into single non-burst AHB transfers. Stalls the CPU until the transfer finishes, then returns read data or an error flag.
- Sits between the CPU MEM stage and the AHB bus/arbiter, directly upstream of the DM slave wrapper.

Parameters:
- TIMEOUT, 16, max data-phase cycles with HREADY low before the transfer is aborted as an error (range 2..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- cpu_req  in  1  CPU data access request, held until cpu_stall drops
- cpu_write  in  1  1=store, 0=load
- cpu_size  in  3  0=byte, 1=half, 2=word (HSIZE encoding)
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data
- cpu_stall  out  1  CPU must hold request/pipeline
- cpu_rdata  out  32  load data, valid when cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  one-cycle error pulse, coincident with cpu_ack
- HBUSREQ  out  1  bus request to arbiter
- HLOCK  out  1  tied 0
- HGRANT  in  1  arbiter grant
- HTRANS  out  2  IDLE=2'b00, NONSEQ=2'b10
- HADDR  out  32
- HWRITE  out  1
- HSIZE  out  3
- HBURST  out  3  always SINGLE (3'b000)
- HWDATA  out  32
- HRDATA  in  32
- HREADY  in  1
- HRESP  in  2  OKAY=0, ERROR=1, RETRY=2, SPLIT=3

Behaviour:
- Reset: rst=0 sampled at posedge forces state IDLE and clears all regs.
  - Outputs at reset: HTRANS=IDLE, HBUSREQ=0, HADDR/HWDATA/HWRITE/HSIZE=0, cpu_ack=0, cpu_err=0, cpu_rdata=0.
  - Reset mid-transfer aborts immediately; HBUSREQ and HTRANS drop on that edge.
- Request latching: the request (write, size, addr, wdata) is latched on the cycle it is accepted in IDLE.
- cpu_stall is combinational: (state!=IDLE && state!=DONE) || (state==IDLE && cpu_req).
- State IDLE: on cpu_req, check alignment.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> DONE with err set. No bus activity.
  - Aligned -> REQ.
- State REQ: HBUSREQ=1, HTRANS=IDLE. On HGRANT && HREADY -> ADDR.
- State ADDR: HTRANS=NONSEQ; HADDR/HWRITE/HSIZE driven from latches; HBUSREQ=0.
  - HREADY=1 -> DATA.
  - HREADY=0 -> hold (previous owner's data phase is extending).
  - Loss of HGRANT while in ADDR with HREADY=0 -> back to REQ.
- State DATA: HTRANS=IDLE; HWDATA=latched wdata on writes, 0 on reads. Wait counter increments each cycle.
  - HREADY=1, HRESP=OKAY: capture HRDATA on reads -> DONE.
  - HRESP=ERROR: hold through the first (HREADY=0) cycle; on HREADY=1 -> DONE with err.
  - HRESP=RETRY/SPLIT with HREADY=1: re-request -> REQ. The retry count is unbounded; the timeout counter resets.
  - Counter reaches TIMEOUT with HREADY still 0 -> DONE with err. cpu_rdata=0 in this case.
- State DONE: cpu_ack=1, cpu_err=err, cpu_rdata=captured data (0 on writes/errors), cpu_stall=0 -> IDLE.
  - A new cpu_req is not accepted in DONE; it is accepted the following cycle in IDLE.
- Zero-wait latency: req in IDLE at T, grant at T+1 (REQ), ADDR at T+2, DATA at T+3, DONE/ack at T+4.
- The DM slave's own wait states extend DATA only.
- cpu_rdata holds its value until the next DONE.

Decomposition:
- Shared package ahb_pkg holds:
  - enums htrans_t, hresp_t, hsize_t, hburst_t;
  - width constants (AHB_DATA_BITS=32, AHB_TRANS_BITS=2, AHB_SIZE_BITS=3, AHB_RESP_BITS=2);
  - master ID constants (M2_ID=4'b0001).
- The FSM state enum is local to the module.
- One sub-module: ahb_align_chk (combinational size/address alignment check), reusable by the instruction-port master.

Test Plan:
- Zero-wait word store: cpu_req, write, addr=0x100, wdata=0xDEADBEEF, grant and HREADY always 1.
  - Required: HTRANS=NONSEQ with HADDR=0x100 at T+2; HWDATA=0xDEADBEEF at T+3; cpu_ack at T+4; cpu_err=0.
- Load with DM slave timing: HREADY low for 2 data-phase cycles, then HRDATA=0x12345678.
  - Required: cpu_rdata=0x12345678 with cpu_ack at T+6; cpu_stall high from T through T+5.
- Grant delayed 3 cycles: HBUSREQ stays 1 and HTRANS stays IDLE until HGRANT; ack latency grows by exactly 3.
- ERROR response (HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1): cpu_ack and cpu_err pulse together; cpu_rdata=0.
- Misaligned word load at addr=0x102: no HBUSREQ; cpu_ack and cpu_err at T+1.
- Timeout and reset:
  - HREADY held 0 in DATA for TIMEOUT=16 cycles: cpu_err pulses.
  - Separately, rst=0 asserted in DATA: next cycle HTRANS=IDLE, HBUSREQ=0, no cpu_ack.
